// File: rtl/led_pattern_gen.sv
// Multi-pattern LED driver: binary count, bouncing light, blink and PWM dim.
// The prescaler tick paces the patterns, and runtime config is applied only on tick edges.
module led_pattern_gen #(
  parameter int NUM_LED  = 10,
  parameter int PRESCALE = 16,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  input  logic                hold,
  output logic [1:0]          mode_o,
  output logic                tick_o,
  output logic [NUM_LED-1:0]  runled
);

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_PWM    = 2'd3
  } mode_t;

  localparam int                 PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int                 IDX_W    = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
  localparam logic [PS_W-1:0]    PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_LED - 1);
  localparam logic [NUM_LED-1:0] LED_ONE  = NUM_LED'(1);

  logic [PS_W-1:0]     presc;
  logic [PS_W-1:0]     presc_nxt;
  logic [PWM_BITS-1:0] pwm_cnt;
  mode_t               mode;
  mode_t               pend_mode;
  mode_t               new_mode;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] pend_duty;
  logic [PWM_BITS-1:0] new_duty;
  logic [PWM_BITS-1:0] eff_duty;
  logic [NUM_LED-1:0]  count;
  logic [NUM_LED-1:0]  count_nxt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic                dir_up;
  logic                dir_nxt;
  logic                blink_on;
  logic                accept;
  logic                apply;
  logic                pwm_on;

  // tick_o is registered from the next prescaler value, so it is high exactly while presc == PRESCALE-1
  assign presc_nxt = (presc == PS_LAST) ? '0 : presc + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc   <= '0;
      tick_o  <= 1'b0;
      pwm_cnt <= '0;
    end else begin
      presc   <= presc_nxt;
      tick_o  <= (presc_nxt == PS_LAST);
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // A config accepted on a tick edge bypasses the pending registers
  assign accept    = cfg_valid && cfg_ready;
  assign apply     = tick_o && (accept || !cfg_ready);
  assign new_mode  = cfg_ready ? mode_t'(cfg_mode) : pend_mode;
  assign new_duty  = cfg_ready ? cfg_duty : pend_duty;
  assign eff_duty  = apply ? new_duty : duty;
  assign pwm_on    = (pwm_cnt < eff_duty);
  assign count_nxt = count + 1'b1;
  assign mode_o    = mode;

  always_comb begin
    idx_nxt = idx;
    dir_nxt = dir_up;
    if (NUM_LED > 1) begin
      if (dir_up) begin
        if (idx == IDX_LAST) begin
          idx_nxt = idx - 1'b1;
          dir_nxt = 1'b0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end else begin
        if (idx == '0) begin
          idx_nxt = idx + 1'b1;
          dir_nxt = 1'b1;
        end else begin
          idx_nxt = idx - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_ready <= 1'b1;
      pend_mode <= MODE_COUNT;
      pend_duty <= '0;
      mode      <= MODE_COUNT;
      duty      <= '0;
      count     <= '0;
      idx       <= '0;
      dir_up    <= 1'b1;
      blink_on  <= 1'b1;
      runled    <= '0;
    end else begin
      if (tick_o) begin
        cfg_ready <= 1'b1;
      end else if (accept) begin
        pend_mode <= mode_t'(cfg_mode);
        pend_duty <= cfg_duty;
        cfg_ready <= 1'b0;
      end

      if (apply) begin
        mode     <= new_mode;
        duty     <= new_duty;
        count    <= '0;
        idx      <= '0;
        dir_up   <= 1'b1;
        blink_on <= 1'b1;
        case (new_mode)
          MODE_COUNT:  runled <= '0;
          MODE_BOUNCE: runled <= LED_ONE;
          MODE_BLINK:  runled <= '1;
          default:     runled <= {NUM_LED{pwm_on}};
        endcase
      end else if (mode == MODE_PWM) begin
        runled <= {NUM_LED{pwm_on}};
      end else if (tick_o && !hold) begin
        case (mode)
          MODE_COUNT: begin
            count  <= count_nxt;
            runled <= count_nxt;
          end
          MODE_BOUNCE: begin
            idx    <= idx_nxt;
            dir_up <= dir_nxt;
            runled <= LED_ONE << idx_nxt;
          end
          default: begin
            blink_on <= !blink_on;
            runled   <= blink_on ? '0 : '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scenario bench for led_pattern_gen with NUM_LED=4, PRESCALE=4, PWM_BITS=3.
// cyc counts clk edges since reset release; a tick edge takes cyc from 3 to 0 modulo 4.
module tb_led_pattern_gen;

  logic       clk;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  logic [2:0] cfg_duty;
  logic       hold;
  logic [1:0] mode_o;
  logic       tick_o;
  logic [3:0] runled;

  int         tests;
  int         fails;
  int         cyc;
  logic [3:0] exp_q[$];
  logic [3:0] exp;
  logic       exp_t;

  led_pattern_gen #(.NUM_LED(4), .PRESCALE(4), .PWM_BITS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_duty  (cfg_duty),
    .hold      (hold),
    .mode_o    (mode_o),
    .tick_o    (tick_o),
    .runled    (runled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic align(input int r);
    for (int i = 0; i < 4 && (cyc % 4) != r; i++) step();
  endtask

  task automatic send_cfg(input logic [1:0] m, input logic [2:0] d);
    align(1);
    cfg_valid = 1'b1;
    cfg_mode  = m;
    cfg_duty  = d;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 8 && cfg_ready !== 1'b1; i++) step();
    tests++;
    if (cfg_ready !== 1'b1 || mode_o !== m) begin
      fails++;
      $display("FAIL send_cfg: ready=%b mode_o=%0d, expected ready=1 mode_o=%0d", cfg_ready, mode_o, m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_duty = 3'd0; hold = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (runled !== 4'h0 || mode_o !== 2'd0 || tick_o !== 1'b0 || cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_values: runled=%h mode=%0d tick=%b ready=%b, expected 0 0 0 1", runled, mode_o, tick_o, cfg_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_count();
    logic [3:0] cur;
    cur = 4'h0;
    exp_q.delete();
    for (int k = 1; k <= 64; k++) exp_q.push_back(4'(k % 16));
    for (int c = 0; c < 256; c++) begin
      exp_t = ((cyc % 4) == 3);
      if (c < 20) begin
        tests++;
        if (tick_o !== exp_t) begin
          fails++;
          $display("FAIL count_tick cyc=%0d: got %b expected %b", cyc, tick_o, exp_t);
        end
      end
      step();
      if ((cyc % 4) == 0 && exp_q.size() > 0) cur = exp_q.pop_front();
      tests++;
      if (runled !== cur) begin
        fails++;
        $display("FAIL count_value cyc=%0d: got %h expected %h", cyc, runled, cur);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL count_ticks: %0d ticks missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_bounce();
    align(0);
    cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_duty = 3'd0;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (cfg_ready !== 1'b0 || mode_o !== 2'd0) begin
        fails++;
        $display("FAIL bounce_pending cyc=%0d: ready=%b mode=%0d, expected ready=0 mode=0", cyc, cfg_ready, mode_o);
      end
      if (i < 2) step();
    end
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    for (int c = 0; c < 32; c++) begin
      step();
      if ((cyc % 4) == 0 && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        tests++;
        if (runled !== exp || cfg_ready !== 1'b1 || mode_o !== 2'd1) begin
          fails++;
          $display("FAIL bounce_step cyc=%0d: runled=%b ready=%b mode=%0d, expected %b 1 1", cyc, runled, cfg_ready, mode_o, exp);
        end
      end
    end
  endtask

  task automatic test_blink_hold();
    align(3);
    cfg_valid = 1'b1; cfg_mode = 2'd2;
    step();
    cfg_valid = 1'b0;
    tests++;
    if (runled !== 4'hF || mode_o !== 2'd2 || cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL blink_apply: runled=%b mode=%0d ready=%b, expected 1111 2 1", runled, mode_o, cfg_ready);
    end
    exp_q = '{4'h0, 4'hF};
    for (int c = 0; c < 8; c++) begin
      step();
      tests++;
      if (cfg_ready !== 1'b1) begin
        fails++;
        $display("FAIL blink_ready cyc=%0d: got %b expected 1", cyc, cfg_ready);
      end
      if ((cyc % 4) == 0 && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        tests++;
        if (runled !== exp) begin
          fails++;
          $display("FAIL blink_step cyc=%0d: got %b expected %b", cyc, runled, exp);
        end
      end
    end
    hold = 1'b1;
    for (int c = 0; c < 12; c++) begin
      exp_t = ((cyc % 4) == 3);
      tests++;
      if (tick_o !== exp_t) begin
        fails++;
        $display("FAIL hold_tick cyc=%0d: got %b expected %b", cyc, tick_o, exp_t);
      end
      step();
      tests++;
      if (runled !== 4'hF) begin
        fails++;
        $display("FAIL hold_frozen cyc=%0d: got %b expected 1111", cyc, runled);
      end
    end
    hold = 1'b0;
    repeat (4) step();
    tests++;
    if (runled !== 4'h0) begin
      fails++;
      $display("FAIL hold_release: got %b expected 0000", runled);
    end
  endtask

  task automatic test_pwm();
    logic [2:0] duties[3];
    int         want_on[3];
    int         on_cnt;
    duties  = '{3'd3, 3'd0, 3'd7};
    want_on = '{3, 0, 7};
    for (int t = 0; t < 3; t++) begin
      hold = (t == 2);
      send_cfg(2'd3, duties[t]);
      on_cnt = 0;
      exp_q.delete();
      for (int c = 0; c < 16; c++) begin
        exp_q.push_back(((cyc % 8) < int'(duties[t])) ? 4'hF : 4'h0);
        step();
        exp = exp_q.pop_front();
        tests++;
        if (runled !== exp) begin
          fails++;
          $display("FAIL pwm_cycle duty=%0d cyc=%0d: got %b expected %b", duties[t], cyc, runled, exp);
        end
        if (c >= 8 && runled === 4'hF) on_cnt++;
      end
      tests++;
      if (on_cnt != want_on[t]) begin
        fails++;
        $display("FAIL pwm_on_count duty=%0d: got %0d expected %0d", duties[t], on_cnt, want_on[t]);
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_ignore_busy();
    align(1);
    cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_duty = 3'd0;
    step();
    cfg_mode = 2'd2;
    step();
    cfg_valid = 1'b0;
    tests++;
    if (cfg_ready !== 1'b0 || mode_o !== 2'd3) begin
      fails++;
      $display("FAIL busy_pending: ready=%b mode=%0d, expected 0 3", cfg_ready, mode_o);
    end
    for (int i = 0; i < 8 && cfg_ready !== 1'b1; i++) step();
    tests++;
    if (mode_o !== 2'd1 || runled !== 4'b0001) begin
      fails++;
      $display("FAIL busy_first_wins: mode=%0d runled=%b, expected 1 0001", mode_o, runled);
    end
    repeat (4) step();
    tests++;
    if (mode_o !== 2'd1 || runled !== 4'b0010) begin
      fails++;
      $display("FAIL busy_after: mode=%0d runled=%b, expected 1 0010", mode_o, runled);
    end
  endtask

  task automatic test_async_reset();
    align(1);
    cfg_valid = 1'b1; cfg_mode = 2'd2;
    step();
    cfg_valid = 1'b0;
    tests++;
    if (cfg_ready !== 1'b0 || runled !== 4'b0010) begin
      fails++;
      $display("FAIL areset_setup: ready=%b runled=%b, expected 0 0010", cfg_ready, runled);
    end
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if (runled !== 4'h0 || mode_o !== 2'd0 || cfg_ready !== 1'b1 || tick_o !== 1'b0) begin
      fails++;
      $display("FAIL areset_immediate: runled=%b mode=%0d ready=%b tick=%b, expected 0000 0 1 0", runled, mode_o, cfg_ready, tick_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
    for (int c = 0; c < 8; c++) begin
      exp_t = ((cyc % 4) == 3);
      exp   = (cyc >= 4) ? 4'h1 : 4'h0;
      tests++;
      if (tick_o !== exp_t || runled !== exp || mode_o !== 2'd0) begin
        fails++;
        $display("FAIL areset_restart cyc=%0d: tick=%b runled=%b mode=%0d, expected %b %b 0", cyc, tick_o, runled, mode_o, exp_t, exp);
      end
      step();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    test_reset();
    test_count();
    test_bounce();
    test_blink_hold();
    test_pwm();
    test_ignore_busy();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the board run-LED counter: drives NUM_LED LEDs with one of four selectable patterns (binary count, bouncing light, blink, PWM dim).
- A single-clock prescaler produces a one-cycle tick enable; no derived clocks.
- Mode and duty are loaded at runtime through a valid/ready handshake and take effect only on tick boundaries.
- Sits at top level beside the status logic; the outputs go straight to the pins.

Parameters:
- NUM_LED, 10: LED count, >=1.
- PRESCALE, 16: clk cycles per tick, >=1. With 1, tick fires every cycle.
- PWM_BITS, 4: width of the PWM counter and of the duty value, >=1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config can be accepted
- cfg_mode  in  2  0=COUNT 1=BOUNCE 2=BLINK 3=PWM
- cfg_duty  in  PWM_BITS  PWM on-threshold
- hold  in  1  freeze pattern advance
- mode_o  out  2  active mode
- tick_o  out  1  prescaler tick, one-cycle pulse
- runled  out  NUM_LED  LED drive, registered

Behaviour:

Reset:
- reset low asserts asynchronously and clears everything immediately, including mid-pattern and with a config pending.
- Reset values: runled=0, mode_o=COUNT(0), duty=0, tick_o=0, cfg_ready=1, prescaler=0, PWM counter=0, pattern state cleared.
- Deassertion is sampled on clk.

Prescaler:
- Counts 0..PRESCALE-1 and wraps.
- tick_o=1 for exactly the cycle in which the count equals PRESCALE-1.
- The first tick occurs in cycle PRESCALE after reset release.
- Free-running: it ignores hold and config activity.

Config handshake:
- Accept occurs when cfg_valid && cfg_ready at a clk edge; mode and duty are captured into pending registers.
- If the accept edge is also a tick edge, the config applies on that same edge and cfg_ready stays 1.
- Otherwise cfg_ready=0 from the next cycle until the next tick edge. On that edge the pending config is applied and cfg_ready returns to 1 the following cycle.
- cfg_valid while cfg_ready=0 is ignored.
- Hold does not block config application.

Mode entry (new mode applied, even if equal to the current mode):
- count=0.
- Bounce position=bit0, direction=up.
- Blink phase=on.
- The applying edge updates runled to the new mode's initial pattern: COUNT gives 0, BOUNCE gives bit0, BLINK gives all ones, PWM is per cycle.

Per-tick pattern advance (skipped when hold=1 on the tick cycle):
- COUNT: count increments modulo 2^NUM_LED; runled=count.
- BOUNCE:
  - one-hot position moves by one toward the current direction;
  - reverses at bit NUM_LED-1 and at bit0, so the sequence is 0,1,..,N-1,N-2,..,0,1,..;
  - end bits are not repeated;
  - with NUM_LED=1 it stays at bit0.
- BLINK: runled toggles between all ones and all zeros.
- Applying config and a hold tick together: the config applies and no advance occurs on that edge.

PWM mode:
- The PWM counter (PWM_BITS wide) increments every clk cycle and wraps. It runs in all modes and ignores hold.
- Every runled bit is registered as (pwm_cnt < duty), giving one cycle latency.
- duty=0 gives always off. duty=2^PWM_BITS-1 gives on for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- hold has no effect in PWM mode.

Registered outputs:
- mode_o updates on the applying edge.

Test Plan:
Bench parameters for all cases: NUM_LED=4, PRESCALE=4, PWM_BITS=3.

1. Reset, then run 20 cycles in COUNT -> tick_o pulses at cycles 4,8,12,16,20; runled steps 0,1,2,3,4,5. Continue to 64 ticks -> value wraps 15->0.
2. cfg_mode=1 accepted mid-interval -> cfg_ready low until the next tick edge; runled=0001 at that edge. Subsequent ticks give 0010,0100,1000,0100,0010,0001,0010.
3. cfg_mode=2 accepted on a tick cycle -> cfg_ready never drops; runled=1111 immediately, then 0000,1111 on the following ticks. hold=1 across 3 ticks -> runled frozen, tick_o keeps pulsing.
4. cfg_mode=3, cfg_duty=3 -> each bit high 3 of every 8 cycles, period 8. duty=0 -> runled stays 0. duty=7 -> low exactly 1 cycle in 8.
5. Second cfg_valid while cfg_ready=0 -> ignored; the first config applies and mode_o shows the first mode.
6. reset low asynchronously mid-bounce with a config pending -> runled=0, mode_o=0, cfg_ready=1 without any clk edge. After release, the first tick arrives 4 cycles later.
